// File: rtl/select_encode_sb.sv
// Instruction register with ra/rb/rc decode into registered one-hot register-file enables,
// immediate extension, and a per-register busy scoreboard raising a read-after-write hazard.
module select_encode_sb #(
  parameter int BITS          = 32,
  parameter int REGISTERS     = 16,
  parameter int REGISTER_BITS = $clog2(REGISTERS),
  parameter int OPCODE_BITS   = 5
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic [BITS-1:0]          ir_in,
  input  logic                     ir_load,
  input  logic [1:0]               field_sel,
  input  logic                     rin,
  input  logic                     rout,
  input  logic                     baout,
  input  logic [1:0]               imm_mode,
  input  logic                     sb_issue,
  input  logic                     sb_retire,
  input  logic [REGISTER_BITS-1:0] sb_retire_idx,
  output logic [BITS-1:0]          ir_q,
  output logic [REGISTERS-1:0]     reg_in_ctrl,
  output logic [REGISTERS-1:0]     reg_out_ctrl,
  output logic                     ba_zero,
  output logic [BITS-1:0]          c_ext,
  output logic [REGISTERS-1:0]     busy_vec,
  output logic                     hazard
);

  localparam int IMM_LEN = BITS - OPCODE_BITS - 3*REGISTER_BITS;
  localparam int RC_LSB  = IMM_LEN;
  localparam int RB_LSB  = IMM_LEN + REGISTER_BITS;
  localparam int RA_LSB  = IMM_LEN + 2*REGISTER_BITS;

  logic [BITS-1:0]          r_ir;
  logic [REGISTERS-1:0]     r_reg_in;
  logic [REGISTERS-1:0]     r_reg_out;
  logic                     r_ba_zero;
  logic [BITS-1:0]          r_c_ext;
  logic [REGISTERS-1:0]     r_busy;

  logic [REGISTER_BITS-1:0] w_ra;
  logic [REGISTER_BITS-1:0] w_rb;
  logic [REGISTER_BITS-1:0] w_rc;
  logic [REGISTER_BITS-1:0] w_idx;
  logic                     w_valid;
  logic [REGISTERS-1:0]     w_idx_oh;
  logic [REGISTERS-1:0]     w_ra_oh;
  logic [REGISTERS-1:0]     w_ret_oh;
  logic                     w_rd_req;
  logic                     w_ba_r0;
  logic [IMM_LEN-1:0]       w_imm;
  logic [BITS-1:0]          w_sext;
  logic [BITS-1:0]          w_zext;
  logic [BITS-1:0]          w_c_ext_next;
  logic [REGISTERS-1:0]     w_busy_next;

  assign w_ra = r_ir[RA_LSB +: REGISTER_BITS];
  assign w_rb = r_ir[RB_LSB +: REGISTER_BITS];
  assign w_rc = r_ir[RC_LSB +: REGISTER_BITS];

  always_comb begin
    w_idx = '0;
    case (field_sel)
      2'b01:   w_idx = w_ra;
      2'b10:   w_idx = w_rb;
      2'b11:   w_idx = w_rc;
      default: w_idx = '0;
    endcase
  end

  assign w_valid = (field_sel != 2'b00);

  // Indices past the last register match no bit, so they yield zero enables and no hazard.
  genvar gi;
  generate
    for (gi = 0; gi < REGISTERS; gi++) begin : g_onehot
      assign w_idx_oh[gi] = (w_idx == REGISTER_BITS'(gi));
      assign w_ra_oh[gi]  = (w_ra == REGISTER_BITS'(gi));
      assign w_ret_oh[gi] = (sb_retire_idx == REGISTER_BITS'(gi));
    end
  endgenerate

  assign w_rd_req = w_valid & (rout | baout);
  assign w_ba_r0  = w_valid & baout & (w_idx == '0);
  assign hazard   = w_rd_req & (|(w_idx_oh & r_busy)) & ~w_ba_r0;

  assign w_imm  = r_ir[IMM_LEN-1:0];
  assign w_sext = {{(BITS-IMM_LEN){w_imm[IMM_LEN-1]}}, w_imm};
  assign w_zext = {{(BITS-IMM_LEN){1'b0}}, w_imm};

  always_comb begin
    w_c_ext_next = '0;
    case (imm_mode)
      2'b00:   w_c_ext_next = w_sext;
      2'b01:   w_c_ext_next = w_zext;
      2'b10:   w_c_ext_next = w_sext << 2;
      default: w_c_ext_next = '0;
    endcase
  end

  // Issue is applied after retire so a same-index collision leaves the register busy.
  assign w_busy_next = (r_busy & ~(sb_retire ? w_ret_oh : '0)) | (sb_issue ? w_ra_oh : '0);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_ir      <= '0;
      r_reg_in  <= '0;
      r_reg_out <= '0;
      r_ba_zero <= 1'b0;
      r_c_ext   <= '0;
      r_busy    <= '0;
    end else begin
      if (ir_load) r_ir <= ir_in;
      r_reg_in  <= (w_valid & rin) ? w_idx_oh : '0;
      r_reg_out <= (w_rd_req & ~hazard & ~w_ba_r0) ? w_idx_oh : '0;
      r_ba_zero <= w_ba_r0;
      r_c_ext   <= w_c_ext_next;
      r_busy    <= w_busy_next;
    end
  end

  assign ir_q         = r_ir;
  assign reg_in_ctrl  = r_reg_in;
  assign reg_out_ctrl = r_reg_out;
  assign ba_zero      = r_ba_zero;
  assign c_ext        = r_c_ext;
  assign busy_vec     = r_busy;

endmodule
